// File: rtl/hysteresis_track.sv
// hysteresis_track: single-pass 3x3 hysteresis turning a 2-bit strength stream into a binary edge map.
module hysteresis_track #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] strength,
  input  logic       str_valid,
  output logic       is_edge,
  output logic       edge_valid,
  output logic       frame_done,
  output logic       overflow
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int FW = $clog2(IMG_WIDTH + 1);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [FW-1:0] F_LAST = FW'(IMG_WIDTH);
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  logic [0:0] state;
  logic [CW-1:0] col, cc;
  logic [RW-1:0] row, cr;
  logic [FW-1:0] fcnt;
  logic [1:0] lb_a [IMG_WIDTH];
  logic [1:0] lb_b [IMG_WIDTH];
  logic [2:0][1:0] wt, wm, wb, nt, nm, nb;
  logic run_ev, fl_ev, ev, produce, lv, rv, tv, bv, nbr, dec, last_pix;
  logic [1:0] x;
  always_comb begin
    run_ev   = state == RUN && str_valid;
    fl_ev    = state == FLUSH;
    ev       = run_ev || fl_ev;
    x        = fl_ev ? 2'd0 : strength;
    nb       = {wb[1:0], x};
    nm       = {wm[1:0], lb_a[col]};
    nt       = {wt[1:0], lb_b[col]};
    produce  = ev && (fl_ev || row > RW'(1) || (row == RW'(1) && col != '0));
    lv       = cc != '0;
    rv       = cc != C_LAST;
    tv       = cr != '0;
    bv       = cr != R_LAST;
    // index 2 is the older (left) column, index 0 the newest (right)
    nbr      = (tv && ((lv && nt[2][1]) || nt[1][1] || (rv && nt[0][1])))
            || (lv && nm[2][1]) || (rv && nm[0][1])
            || (bv && ((lv && nb[2][1]) || nb[1][1] || (rv && nb[0][1])));
    dec      = nm[1][1] || (nm[1] == 2'd1 && nbr);
    last_pix = cc == C_LAST && cr == R_LAST;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      col        <= '0;
      row        <= '0;
      cc         <= '0;
      cr         <= '0;
      fcnt       <= '0;
      wt         <= '0;
      wm         <= '0;
      wb         <= '0;
      is_edge    <= 1'b0;
      edge_valid <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      for (int i = 0; i < IMG_WIDTH; i++) begin
        lb_a[i] <= '0;
        lb_b[i] <= '0;
      end
    end else begin
      edge_valid <= produce;
      is_edge    <= produce && dec;
      frame_done <= produce && last_pix;
      if (fl_ev && str_valid) overflow <= 1'b1;
      if (ev) begin
        wb        <= nb;
        wm        <= nm;
        wt        <= nt;
        lb_a[col] <= x;
        lb_b[col] <= lb_a[col];
        col       <= col == C_LAST ? '0 : col + 1'b1;
      end
      if (run_ev && col == C_LAST) row <= row == R_LAST ? '0 : row + 1'b1;
      if (run_ev && col == C_LAST && row == R_LAST) state <= FLUSH;
      if (fl_ev) begin
        fcnt <= fcnt + 1'b1;
        if (fcnt == F_LAST) begin
          state <= RUN;
          fcnt  <= '0;
          col   <= '0;
        end
      end
      if (produce) begin
        cc <= cc == C_LAST ? '0 : cc + 1'b1;
        if (cc == C_LAST) cr <= cr == R_LAST ? '0 : cr + 1'b1;
      end
    end
  end
endmodule

// File: doc/hysteresis_track.md
Name: hysteresis_track

Overview:
- Stage directly downstream of double thresholding. Consumes the 2-bit per-pixel strength stream in raster order and produces the final binary Canny edge map.
- Performs single-pass hysteresis over a 3x3 neighbourhood:
  - a strong pixel is an edge;
  - a weak pixel is an edge only if at least one of its 8 neighbours is strong.
- Uses two line buffers of strength values and an internal flush that drains the last row after frame end.

Parameters:
IMG_WIDTH, 640, pixels per row (>=3)
IMG_HEIGHT, 480, rows per frame (>=3)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
strength  input  2  0=none, 1=weak, 2=strong, 3=treated as strong
str_valid  input  1  strength valid this cycle; no backpressure
edge  output  1  final edge decision for current output pixel
edge_valid  output  1  edge valid this cycle
frame_done  output  1  1-cycle pulse coincident with last edge_valid of frame
overflow  output  1  sticky; set if str_valid arrives during FLUSH

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high.
- Reset values:
  - edge=0, edge_valid=0, frame_done=0, overflow=0.
  - Input column/row counters=0. State=RUN.
  - Line buffers and window registers cleared to 0.
- Pixel events:
  - In RUN, each cycle with str_valid=1 is one event at linear index k (0..W*H-1). Gaps (str_valid=0) are allowed and freeze the pipeline.
  - In FLUSH, the block generates W+1 internal events, one per cycle, with strength 0 and no gaps.
  - Total events per frame = W*H + W + 1.
- Windowing:
  - Event k shifts the new strength into the 3x3 window and the line buffers.
  - The centre of the window is pixel k-(W+1).
  - When k >= W+1, an output is produced for that centre.
- Border rule: neighbours outside the image count as strength 0.
  - Row -1 and row H do not exist.
  - There is no wrap across row ends: column W-1 is not a neighbour of column 0 in the next row.
  - Implement with column/row validity masks, not by clearing the buffers.
- Decision:
  - edge = (centre>=2) | (centre==1 & any neighbour>=2).
  - Weak pixels promoted by a weak neighbour do not propagate further (single pass only).
- Latency and ordering:
  - edge and edge_valid are registered: they assert the cycle after the triggering event.
  - Outputs appear in raster order, exactly W*H per frame.
- State machine:
  - RUN -> FLUSH on the cycle after accepting event k = W*H-1.
  - FLUSH -> RUN after the W+1-th flush event. Counters reset to 0 and the next frame begins.
- frame_done:
  - Asserts together with the edge_valid for pixel (H-1, W-1).
  - That output is the last flush output: it is produced by the final flush event, with frame_done asserting the cycle after.
- Input during FLUSH: str_valid is dropped and overflow is set (sticky until rst). The flush itself completes unaffected.
- Back-to-back frames:
  - The first event of frame N+1 is accepted in the cycle after FLUSH ends.
  - The line buffers need not be cleared between frames; border masks guarantee independence.
- Reset mid-frame: all partial state is discarded. The first valid pixel after reset is treated as (0,0).
- Counters are sized $clog2(W) and $clog2(H). Column wraps at W-1 and row increments; row wraps at H-1.

Test Plan:
- Reset, W=4, H=3, all 12 pixels weak (1), str_valid continuous:
  - 12 edge_valid pulses, all edge=0.
  - frame_done once, on the 12th pulse.
  - First edge_valid occurs 1 cycle after the 6th input (k=5).
- W=4, H=3, strong at (1,1), all others weak:
  - edge=1 for (0,0),(0,1),(0,2),(1,0),(1,1),(1,2),(2,0),(2,1),(2,2).
  - edge=0 for (0,3),(1,3),(2,3).
- No-wrap check, W=4, H=3: strong at (0,3), weak at (1,0), others 0:
  - (1,0) edge=0.
  - (0,3) edge=1.
- Same stimulus as the previous scenario with random 0-3 cycle gaps on str_valid: identical edge sequence, count 12, one frame_done.
- Input during flush:
  - Drive str_valid=1 on the cycle after the last pixel of the frame.
  - overflow=1 and stays 1.
  - Still exactly 12 outputs.
  - Next frame starts at (0,0) after FLUSH.
- Reset mid-frame:
  - Assert rst after 7 inputs.
  - All outputs return to 0.
  - Then send a full frame with strong at (2,3), others weak: edge=1 only at (1,2),(1,3),(2,2),(2,3).
- Back-to-back frames: two frames of 12 pixels each → two frame_done pulses, 24 total edge_valid, no overflow.
